// File: rtl/vga_axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_axil_pkg
//  Description : Shared response codes and index helpers for the VGA AXI4-Lite
//                register slave.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Width of a word index able to address n words (never narrower than 1 bit).
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic idx_in_range(input int unsigned idx, input int unsigned n);
        return idx < n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : vga_reg_file
//  Description : NUM_REGS x 32-bit word store, one byte-enabled write port and
//                two registered read ports (AXI side, pixel side).
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_reg_file
    import vga_axil_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int AXI_IDX_W = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_wr_en,
    input  logic [AXI_IDX_W-1:0]             i_wr_idx,
    input  logic [31:0]                      i_wr_data,
    input  logic [3:0]                       i_wr_strb,
    input  logic                             i_rd_en,
    input  logic [AXI_IDX_W-1:0]             i_rd_idx,
    output logic [31:0]                      o_rd_data,
    input  logic [idx_width(NUM_REGS)-1:0]   i_pix_idx,
    output logic [31:0]                      o_pix_data
);

    localparam int c_mem_idx_w = idx_width(NUM_REGS);

    logic [31:0]            r_mem [NUM_REGS];
    logic [31:0]            r_rd_data;
    logic [31:0]            r_pix_data;

    logic                   w_wr_hit;
    logic                   w_rd_hit;
    logic                   w_pix_hit;
    logic [c_mem_idx_w-1:0] w_wr_slot;
    logic [c_mem_idx_w-1:0] w_rd_slot;
    logic [31:0]            w_wr_mask;
    logic [31:0]            w_wr_merged;
    logic [31:0]            w_pix_next;

    assign w_wr_hit  = i_wr_en && idx_in_range(32'(i_wr_idx), NUM_REGS);
    assign w_rd_hit  = idx_in_range(32'(i_rd_idx), NUM_REGS);
    assign w_pix_hit = idx_in_range(32'(i_pix_idx), NUM_REGS);
    // Slot narrowing is safe: every use is qualified by the matching range check.
    assign w_wr_slot = i_wr_idx[c_mem_idx_w-1:0];
    assign w_rd_slot = i_rd_idx[c_mem_idx_w-1:0];

    always_comb begin
        w_wr_mask = '0;
        for (int b = 0; b < 4; b++) begin
            w_wr_mask[8*b +: 8] = {8{i_wr_strb[b]}};
        end
    end

    assign w_wr_merged = (r_mem[w_wr_slot] & ~w_wr_mask) | (i_wr_data & w_wr_mask);

    // The pixel port forwards a same-cycle commit so the display sees it one cycle later.
    always_comb begin
        w_pix_next = '0;
        if (w_pix_hit) begin
            w_pix_next = r_mem[i_pix_idx];
            if (w_wr_hit && (w_wr_slot == i_pix_idx)) begin
                w_pix_next = w_wr_merged;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data  <= '0;
            r_pix_data <= '0;
        end else begin
            if (w_wr_hit) begin
                r_mem[w_wr_slot] <= w_wr_merged;
            end
            // AXI read samples the pre-write contents; data holds between reads.
            if (i_rd_en) begin
                r_rd_data <= w_rd_hit ? r_mem[w_rd_slot] : 32'h0;
            end
            r_pix_data <= w_pix_next;
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_pix_data = r_pix_data;

endmodule
`default_nettype wire

// File: rtl/vga_axil_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : vga_axil_reg_slave
//  Description : AXI4-Lite slave register bank with a read-only pixel side port.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_axil_reg_slave
    import vga_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 16
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic [idx_width(NUM_REGS)-1:0]    pix_rd_idx,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     pix_rd_data
);

    localparam int c_axi_idx_w = C_S_AXI_ADDR_WIDTH - 2;

    logic                   r_aw_held;
    logic                   r_awready;
    logic [c_axi_idx_w-1:0] r_aw_idx;
    logic                   r_w_held;
    logic                   r_wready;
    logic [31:0]            r_w_data;
    logic [3:0]             r_w_strb;
    logic                   r_bvalid;
    logic [1:0]             r_bresp;
    logic                   r_arready;
    logic                   r_rvalid;
    logic [1:0]             r_rresp;

    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_ar_hs;
    logic                   w_commit;
    logic                   w_aw_held_nxt;
    logic                   w_w_held_nxt;
    logic                   w_rvalid_nxt;
    logic [c_axi_idx_w-1:0] w_ar_idx;
    logic                   w_unused_addr_bits;

    assign w_aw_hs  = S_AXI_AWVALID && r_awready;
    assign w_w_hs   = S_AXI_WVALID  && r_wready;
    assign w_ar_hs  = S_AXI_ARVALID && r_arready;
    assign w_ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_commit = r_aw_held && r_w_held && (!r_bvalid || S_AXI_BREADY);

    // Byte offset within a word carries no meaning here.
    assign w_unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Readies track the next value of their holding flag, keeping them registered.
    assign w_aw_held_nxt = w_commit ? 1'b0 : (w_aw_hs ? 1'b1 : r_aw_held);
    assign w_w_held_nxt  = w_commit ? 1'b0 : (w_w_hs  ? 1'b1 : r_w_held);
    assign w_rvalid_nxt  = w_ar_hs  ? 1'b1 : (S_AXI_RREADY ? 1'b0 : r_rvalid);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_aw_held <= 1'b0;
            r_awready <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_wready  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_aw_held <= w_aw_held_nxt;
            r_awready <= !w_aw_held_nxt;
            r_w_held  <= w_w_held_nxt;
            r_wready  <= !w_w_held_nxt;
            if (w_aw_hs) begin
                r_aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_w_hs) begin
                r_w_data <= S_AXI_WDATA;
                r_w_strb <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= idx_in_range(32'(r_aw_idx), NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
            r_rvalid  <= w_rvalid_nxt;
            r_arready <= !w_rvalid_nxt;
            if (w_ar_hs) begin
                r_rresp <= idx_in_range(32'(w_ar_idx), NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    vga_reg_file #(
        .NUM_REGS  (NUM_REGS),
        .AXI_IDX_W (c_axi_idx_w)
    ) u_reg_file (
        .clk        (ACLK),
        .rst_n      (ARESETN),
        .i_wr_en    (w_commit),
        .i_wr_idx   (r_aw_idx),
        .i_wr_data  (r_w_data),
        .i_wr_strb  (r_w_strb),
        .i_rd_en    (w_ar_hs),
        .i_rd_idx   (w_ar_idx),
        .o_rd_data  (S_AXI_RDATA),
        .i_pix_idx  (pix_rd_idx),
        .o_pix_data (pix_rd_data)
    );

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_vga_axil_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_axil_reg_slave
//  Description : Scoreboard bench for vga_axil_reg_slave (NUM_REGS = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_axil_reg_slave;

    localparam int         NR     = 8;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [5:0]  S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [5:0]  S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [2:0]  pix_rd_idx;
    logic [31:0] pix_rd_data;

    vga_axil_reg_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (6),
        .NUM_REGS           (NR)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .pix_rd_idx    (pix_rd_idx),
        .pix_rd_data   (pix_rd_data)
    );

    always #5 ACLK = ~ACLK;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_mem [NR];
    logic [1:0]  bq [$];
    logic [33:0] rq [$];

    always @(posedge ACLK) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference model: a word array updated with byte-lane semantics.
    function automatic void model_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx = int'(addr) / 4;
        if (idx < NR) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
            bq.push_back(OKAY);
        end else begin
            bq.push_back(SLVERR);
        end
    endfunction

    function automatic logic [33:0] model_read(input logic [5:0] addr);
        int idx = int'(addr) / 4;
        if (idx < NR) return {model_mem[idx], OKAY};
        return {32'h0, SLVERR};
    endfunction

    // Monitor: compare each response at the moment it is handed over.
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (bq.size() == 0) check("b_unexpected", 1, 0);
                else check("b_resp", S_AXI_BRESP, bq.pop_front());
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (rq.size() == 0) check("r_unexpected", 1, 0);
                else check("r_data_resp", {S_AXI_RDATA, S_AXI_RRESP}, rq.pop_front());
            end
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic write_txn(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, output int hs_cyc);
        int aw_start = (lead > 0) ? lead : 0;
        int w_start  = (lead < 0) ? -lead : 0;
        bit aw_done = 0;
        bit w_done  = 0;
        int t = 0;
        hs_cyc = -1;
        model_write(addr, data, strb);
        S_AXI_AWADDR = addr;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        while (!(aw_done && w_done) && t < 40) begin
            S_AXI_AWVALID = !aw_done && (t >= aw_start);
            S_AXI_WVALID  = !w_done  && (t >= w_start);
            @(negedge ACLK);
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin aw_done = 1; hs_cyc = cyc; end
            if (S_AXI_WVALID  && S_AXI_WREADY)  begin w_done  = 1; hs_cyc = cyc; end
            @(posedge ACLK); #1;
            t++;
        end
        S_AXI_AWVALID = 0;
        S_AXI_WVALID  = 0;
        if (!(aw_done && w_done)) check("write_accept_timeout", 0, 1);
    endtask

    task automatic read_txn(input logic [5:0] addr, output int hs_cyc);
        bit done = 0;
        hs_cyc = -1;
        rq.push_back(model_read(addr));
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge ACLK);
            if (S_AXI_ARREADY) begin done = 1; hs_cyc = cyc; end
            @(posedge ACLK); #1;
        end
        S_AXI_ARVALID = 0;
        if (!done) check("read_accept_timeout", 0, 1);
    endtask

    task automatic wait_bvalid(output int seen);
        seen = -1;
        for (int t = 0; t < 40 && seen < 0; t++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID) seen = cyc;
        end
        if (seen < 0) check("bvalid_timeout", 0, 1);
        @(posedge ACLK); #1;
    endtask

    task automatic wait_rvalid(output int seen);
        seen = -1;
        for (int t = 0; t < 40 && seen < 0; t++) begin
            @(negedge ACLK);
            if (S_AXI_RVALID) seen = cyc;
        end
        if (seen < 0) check("rvalid_timeout", 0, 1);
        @(posedge ACLK); #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 60) begin
            @(posedge ACLK); #1;
            n++;
        end
        if (n >= 60) begin
            check("drain_timeout", {bq.size(), rq.size()}, 0);
            bq.delete();
            rq.delete();
        end
        @(posedge ACLK); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge ACLK); #1; end
    endtask

    task automatic pix_sweep(input string nm);
        for (int i = 0; i < NR; i++) begin
            pix_rd_idx = 3'(i);
            @(posedge ACLK); #1;
            @(negedge ACLK);
            check(nm, pix_rd_data, model_mem[i]);
            @(posedge ACLK); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, seen, k, lead;
        logic [31:0] old, data;
        logic [5:0]  addr;

        for (int i = 0; i < NR; i++) model_mem[i] = '0;
        ARESETN = 0;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_WVALID = 0; S_AXI_BREADY = 1; S_AXI_ARADDR = '0; S_AXI_ARVALID = 0;
        S_AXI_RREADY = 1; pix_rd_idx = '0;

        // Reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("reset_handshake_outputs",
              {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID}, 0);
        check("reset_resp_data", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, pix_rd_data}, 0);
        @(posedge ACLK); #1;
        ARESETN = 1;
        @(negedge ACLK);
        check("ready_low_in_release_cycle", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        @(posedge ACLK); #1;
        @(negedge ACLK);
        check("ready_high_after_release", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        @(posedge ACLK); #1;

        // 1: AW+W together, B two cycles later; read back one cycle after AR
        write_txn(6'h08, 32'hDEADBEEF, 4'hF, 0, hs);
        wait_bvalid(seen);
        check("t1_b_latency", seen - hs, 2);
        read_txn(6'h08, hs);
        wait_rvalid(seen);
        check("t1_r_latency", seen - hs, 1);
        drain();

        // 2: W three cycles ahead of AW, partial strobe
        write_txn(6'h00, 32'h11223344, 4'b0101, 3, hs);
        drain();
        read_txn(6'h00, hs);
        drain();

        // 3: out-of-range index
        write_txn(6'h3C, 32'hCAFEF00D, 4'hF, 0, hs);
        drain();
        read_txn(6'h3C, hs);
        drain();
        pix_sweep("t3_pix_unchanged");

        // 4: B back-pressure; second write accepted but held
        S_AXI_BREADY = 0;
        pix_rd_idx = 3'd2;
        write_txn(6'h04, 32'h55AA33CC, 4'hF, 0, hs);
        wait_bvalid(seen);
        old = model_mem[2];
        write_txn(6'h08, 32'h0BADF00D, 4'hF, 0, hs);
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            check("t4_bvalid_held", {S_AXI_BVALID, S_AXI_BRESP}, {1'b1, OKAY});
            check("t4_aw_w_held", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
            check("t4_no_commit", pix_rd_data, old);
            @(posedge ACLK); #1;
        end
        S_AXI_BREADY = 1;
        drain();
        @(negedge ACLK);
        check("t4_commit_after_b", pix_rd_data, 32'h0BADF00D);
        @(posedge ACLK); #1;

        // 5: commit and AR to the same word in one cycle
        write_txn(6'h0C, 32'h01020304, 4'hF, 0, hs);
        drain();
        pix_rd_idx = 3'd3;
        old = model_mem[3];
        write_txn(6'h0C, 32'hA5A5A5A5, 4'hF, 0, hs);
        rq.push_back({old, OKAY});
        S_AXI_ARADDR  = 6'h0C;
        S_AXI_ARVALID = 1;
        @(negedge ACLK);
        check("t5_ar_in_commit_cycle", S_AXI_ARREADY, 1);
        check("t5_pix_before_commit", pix_rd_data, old);
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 0;
        @(negedge ACLK);
        check("t5_pix_after_commit", pix_rd_data, 32'hA5A5A5A5);
        @(posedge ACLK); #1;
        drain();

        // 6: reset while an address is held
        S_AXI_AWADDR  = 6'h14;
        S_AXI_AWVALID = 1;
        @(negedge ACLK);
        check("t6_aw_accepted", S_AXI_AWREADY, 1);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 0;
        #2 ARESETN = 0;
        for (int i = 0; i < NR; i++) model_mem[i] = '0;
        @(negedge ACLK);
        check("t6_reset_outputs",
              {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, pix_rd_data}, 0);
        @(posedge ACLK); #1;
        ARESETN = 1;
        idle(2);
        check("t6_no_stray_b", S_AXI_BVALID, 0);
        write_txn(6'h14, 32'h600DCAFE, 4'b1100, -2, hs);
        drain();
        read_txn(6'h14, hs);
        drain();
        pix_sweep("t6_pix_after_reset");

        // Randomized traffic against the word-array model
        for (int n = 0; n < 60; n++) begin
            k    = $urandom_range(0, 3);
            addr = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 9) < 6) begin
                data = $urandom;
                lead = $urandom_range(0, 6) - 3;
                S_AXI_BREADY = (k == 0);
                write_txn(addr, data, 4'($urandom_range(0, 15)), lead, hs);
                idle(k);
                S_AXI_BREADY = 1;
            end else begin
                S_AXI_RREADY = (k == 0);
                read_txn(addr, hs);
                idle(k);
                S_AXI_RREADY = 1;
            end
            drain();
        end
        pix_sweep("rand_pix_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
